keypad_scanner: RTL and testbench

Row-scanning front end for the 4x4 matrix keypad. Drives one keypad row low at a time, samples the column lines, debounces press and release, and emits a one-cycle `key_valid` strobe with a 4-bit hex `key_code`. It sits directly upstream of the two-digit history/display path: each `key_valid` shifts `key_code` into the right digit and the old right digit into the left.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/col_sync2.sv | 21 ++
 rtl/keypad_scanner.sv | 116 +++++++++++
 tb/tb_keypad_scanner.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad row scanner.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

   localparam logic [3:0] ROW_DRIVE_RESET = 4'b1110;

   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic logic [3:0] row_drive(input logic [1:0] row);
      return ~(4'b0001 << row);
   endfunction

   // Returns {hit, index}; hit is set only when exactly one column reads low.
   function automatic logic [2:0] single_low(input logic [3:0] c);
      logic [2:0] r;
      case (c)
         4'b1110: r = 3'b100;
         4'b1101: r = 3'b101;
         4'b1011: r = 3'b110;
         4'b0111: r = 3'b111;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/col_sync2.sv
// Two-flop synchronizer for the keypad column bus; idles at all-ones (no key).
module col_sync2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 4'b1111;
         q    <= 4'b1111;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row drive, column sampling, press/release debounce.
// Define KEYPAD_COL_SYNC_EN to pass col through a two-flop synchronizer.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 4096,
   parameter int DEBOUNCE_CYCLES = 480000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col,
   output logic [3:0] r_sel,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic [1:0] state_dbg
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

   scan_state_t   state;
   logic [1:0]    row;
   logic [1:0]    lcol;
   logic [DW-1:0] dwell;
   logic [BW-1:0] deb;
   logic [3:0]    col_s;
   logic [2:0]    hit;

`ifdef KEYPAD_COL_SYNC_EN
   col_sync2 u_col_sync (
      .clk   (clk),
      .reset (reset),
      .d     (col),
      .q     (col_s)
   );
`else
   assign col_s = col;
`endif

   assign hit       = single_low(col_s);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= SCAN;
         row       <= 2'd0;
         lcol      <= 2'd0;
         dwell     <= '0;
         deb       <= '0;
         r_sel     <= ROW_DRIVE_RESET;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               if (dwell == DWELL_LAST) begin
                  dwell <= '0;
                  if (hit[2]) begin
                     lcol  <= hit[1:0];
                     deb   <= '0;
                     state <= DEBOUNCE;
                  end else begin
                     // Ghosted multi-key reads are skipped like an empty row.
                     row   <= row + 2'd1;
                     r_sel <= row_drive(row + 2'd1);
                  end
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (col_s[lcol]) begin
                  state <= SCAN;
                  dwell <= '0;
                  deb   <= '0;
               end else if (deb == DEB_LAST) begin
                  key_code  <= KEY_MAP[row][lcol];
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  deb       <= '0;
                  state     <= HELD;
               end else begin
                  deb <= deb + 1'b1;
               end
            end
            HELD: begin
               if (col_s[lcol]) begin
                  deb   <= '0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               if (!col_s[lcol]) begin
                  deb <= '0;
               end else if (deb == DEB_LAST) begin
                  key_held <= 1'b0;
                  dwell    <= '0;
                  deb      <= '0;
                  row      <= row + 2'd1;
                  r_sel    <= row_drive(row + 2'd1);
                  state    <= SCAN;
               end else begin
                  deb <= deb + 1'b1;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] col;
   logic [3:0] r_sel;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic [1:0] state_dbg;
   logic [15:0] pressed = '0;
   logic [3:0] sync_d = 4'hF;
   logic [3:0] sync_q;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [3:0] exp_q[$];
   logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its column low while its row is driven.
   function automatic logic [3:0] keypad_cols(input logic [3:0] rs, input logic [15:0] pk);
      logic [3:0] c;
      c = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            if (!rs[r] && pk[r*4+k]) c[k] = 1'b0;
      return c;
   endfunction

   function automatic logic [3:0] drive_of(input int r);
      logic [3:0] v;
      v = 4'b1111;
      v[r] = 1'b0;
      return v;
   endfunction

   assign col = keypad_cols(r_sel, pressed);

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .col       (col),
      .r_sel     (r_sel),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .state_dbg (state_dbg)
   );

   col_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sync_d),
      .q     (sync_q)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      pressed = '0;
      repeat (3) step();
      reset = 1'b1;
      cyc = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      pressed = '0;
      repeat (3) step();
      checks++; if (r_sel !== 4'b1110) begin errors++; $display("FAIL reset_r_sel: got %b expected 1110", r_sel); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b expected 0", key_held); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
      checks++; if (sync_q !== 4'b1111) begin errors++; $display("FAIL reset_sync_q: got %b expected 1111", sync_q); end
   endtask

   task automatic test_idle_scan();
      int nvalid;
      nvalid = 0;
      do_reset();
      for (int k = 1; k <= 24; k++) begin
         step();
         if (key_valid) nvalid++;
         checks++;
         if (r_sel !== drive_of((k / SD) % 4)) begin
            errors++; $display("FAIL idle_r_sel edge %0d: got %b expected %b", k, r_sel, drive_of((k / SD) % 4));
         end
      end
      checks++; if (nvalid != 0) begin errors++; $display("FAIL idle_no_valid: got %0d pulses expected 0", nvalid); end
   endtask

   task automatic test_press_row1();
      int vedge;
      do_reset();
      pressed[1*4+2] = 1'b1;
      vedge = SD * 2 + DB;
      for (int k = 1; k <= 24; k++) begin
         step();
         checks++;
         if (key_valid !== (k == vedge)) begin
            errors++; $display("FAIL press_valid edge %0d: got %b expected %b", k, key_valid, (k == vedge));
         end
         if (k == vedge) begin
            checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL press_code: got %h expected 6", key_code); end
            checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b expected 1", key_held); end
         end
         if (k >= SD * 2) begin
            checks++; if (r_sel !== 4'b1101) begin errors++; $display("FAIL press_frozen edge %0d: got %b expected 1101", k, r_sel); end
         end
      end
      pressed = '0;
      for (int k = 25; k <= 24 + 1 + DB; k++) begin
         step();
         if (k == 24 + DB) begin
            checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held_pre_drop: got %b expected 1", key_held); end
         end
      end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL press_held_drop: got %b expected 0", key_held); end
      checks++; if (r_sel !== drive_of(2)) begin errors++; $display("FAIL press_next_row: got %b expected %b", r_sel, drive_of(2)); end
   endtask

   task automatic test_bounce();
      int nvalid, vedge, last_bounce, last_low, dedge;
      nvalid = 0; vedge = -1; dedge = -1;
      do_reset();
      while (cyc < 15) step();
      pressed[3*4+1] = 1'b1;
      while (cyc < 18) step();
      pressed = '0;
      step();
      pressed[3*4+1] = 1'b1;
      last_bounce = cyc;
      while (cyc < 35) begin
         step();
         if (key_valid) begin
            nvalid++;
            if (vedge < 0) vedge = cyc;
            checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL bounce_code: got %h expected 0", key_code); end
         end
      end
      checks++; if (nvalid != 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", nvalid); end
      checks++; if (vedge != last_bounce + SD + DB) begin errors++; $display("FAIL bounce_latency: got edge %0d expected %0d", vedge, last_bounce + SD + DB); end
      // Release bounce: high 3, low 1, then high.
      pressed = '0;
      while (cyc < 38) step();
      pressed[3*4+1] = 1'b1;
      step();
      pressed = '0;
      last_low = cyc;
      nvalid = 0;
      while (cyc < 52) begin
         step();
         if (key_valid) nvalid++;
         if (dedge < 0 && !key_held) begin
            dedge = cyc;
            checks++; if (r_sel !== 4'b1110) begin errors++; $display("FAIL bounce_wrap_row: got %b expected 1110", r_sel); end
         end
      end
      checks++; if (dedge != last_low + DB) begin errors++; $display("FAIL bounce_release_edge: got %0d expected %0d", dedge, last_low + DB); end
      checks++; if (nvalid != 0) begin errors++; $display("FAIL bounce_second_valid: got %0d expected 0", nvalid); end
   endtask

   task automatic test_multi_key();
      int nvalid, nheld;
      nvalid = 0; nheld = 0;
      do_reset();
      pressed[0] = 1'b1;
      pressed[2] = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (key_valid) nvalid++;
         if (key_held) nheld++;
         checks++;
         if (r_sel !== drive_of((k / SD) % 4)) begin
            errors++; $display("FAIL multi_r_sel edge %0d: got %b expected %b", k, r_sel, drive_of((k / SD) % 4));
         end
      end
      checks++; if (nvalid != 0) begin errors++; $display("FAIL multi_valid: got %0d expected 0", nvalid); end
      checks++; if (nheld != 0) begin errors++; $display("FAIL multi_held: got %0d expected 0", nheld); end
   endtask

   task automatic test_reset_mid_debounce();
      int nvalid;
      nvalid = 0;
      do_reset();
      pressed[2*4+2] = 1'b1;
      while (cyc < SD * 3 + DB) step();
      checks++; if (key_valid !== 1'b1 || key_code !== 4'h9) begin
         errors++; $display("FAIL mid_first_key: got valid %b code %h expected 1 9", key_valid, key_code);
      end
      while (cyc < 22) step();
      pressed = '0;
      while (cyc < 22 + 1 + DB) step();
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_release: got %b expected 0", key_held); end
      pressed[0*4+1] = 1'b1;
      while (cyc < 43) step();
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL mid_in_debounce: got %0d expected 1", state_dbg); end
      reset = 1'b0;
      #1;
      checks++; if (r_sel !== 4'b1110) begin errors++; $display("FAIL mid_r_sel: got %b expected 1110", r_sel); end
      checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL mid_key_code: got %h expected 0", key_code); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_key_held: got %b expected 0", key_held); end
      checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL mid_state: got %0d expected 0", state_dbg); end
      repeat (3) begin
         step();
         if (key_valid) nvalid++;
      end
      pressed = '0;
      reset = 1'b1;
      cyc = 0;
      repeat (30) begin
         step();
         if (key_valid) nvalid++;
      end
      checks++; if (nvalid != 0) begin errors++; $display("FAIL mid_no_pulse: got %0d expected 0", nvalid); end
   endtask

   task automatic test_random_keys();
      int ref_edge, next_row, r, c, p, j, exp_edge, q, exp_drop, hold;
      logic [3:0] exp_code;
      do_reset();
      exp_q.delete();
      ref_edge = 0;
      next_row = 0;
      for (int it = 0; it < 12; it++) begin
         repeat ($urandom_range(0, 9)) begin
            step();
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rand_idle_valid it %0d: got 1 expected 0", it); end
         end
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         pressed = '0;
         pressed[r*4+c] = 1'b1;
         p = cyc;
         exp_q.push_back(key_map[r*4+c]);
         // First sample of row r strictly after the press, counting from the last scan restart.
         j = 0;
         while (!(((next_row + j) % 4 == r) && (ref_edge + SD * (j + 1) > p)) && j < 64) j++;
         exp_edge = ref_edge + SD * (j + 1) + DB;
         while (!key_valid && cyc <= exp_edge + 10) step();
         checks++;
         if (!key_valid) begin
            errors++; $display("FAIL rand_timeout it %0d: no key_valid by edge %0d expected %0d", it, cyc, exp_edge);
            exp_q.delete();
            do_reset();
            ref_edge = 0; next_row = 0;
            continue;
         end
         if (cyc != exp_edge) begin errors++; $display("FAIL rand_latency it %0d: got edge %0d expected %0d", it, cyc, exp_edge); end
         exp_code = exp_q.pop_front();
         checks++; if (key_code !== exp_code) begin errors++; $display("FAIL rand_code it %0d: got %h expected %h", it, key_code, exp_code); end
         hold = $urandom_range(0, 5);
         repeat (hold) begin
            step();
            checks++;
            if (key_held !== 1'b1 || key_valid !== 1'b0 || r_sel !== drive_of(r)) begin
               errors++; $display("FAIL rand_hold it %0d: got held %b valid %b r_sel %b expected 1 0 %b", it, key_held, key_valid, r_sel, drive_of(r));
            end
         end
         pressed = '0;
         q = cyc;
         exp_drop = q + 1 + DB;
         while (key_held && cyc <= exp_drop + 10) begin
            step();
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rand_release_valid it %0d: got 1 expected 0", it); end
         end
         checks++;
         if (cyc != exp_drop) begin errors++; $display("FAIL rand_release it %0d: got edge %0d expected %0d", it, cyc, exp_drop); end
         ref_edge = cyc;
         next_row = (r + 1) % 4;
      end
   endtask

   task automatic test_col_sync();
      logic [3:0] hist [$];
      logic [3:0] v;
      do_reset();
      hist.delete();
      for (int k = 0; k < 10; k++) begin
         v = 4'($urandom_range(0, 15));
         sync_d = v;
         hist.push_back(v);
         step();
         if (hist.size() > 2) v = hist.pop_front();
         if (k >= 2) begin
            checks++; if (sync_q !== hist[0]) begin errors++; $display("FAIL sync_delay k %0d: got %b expected %b", k, sync_q, hist[0]); end
         end
      end
      sync_d = 4'hF;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_idle_scan();
      test_press_row1();
      test_bounce();
      test_multi_key();
      test_reset_mid_debounce();
      test_random_keys();
      test_col_sync();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
